rv_mem_resp: RTL and testbench

//  Memory responder for the multicycle RISC-V core: serves instruction fetches and data

---
 rtl/rv_mem_resp.sv | 137 +++++++++++++
 tb/tb_rv_mem_resp.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_resp.sv
// Memory responder for the multicycle RISC-V core: one word-organised array shared by
// instruction fetch and data ports, one access in flight, per-port wait states.
module rv_mem_resp #(
    parameter int DPWIDTH  = 32,
    parameter int MEMWORDS = 1024,
    parameter int IWAIT    = 0,
    parameter int DWAIT    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               imem_req,
    input  logic [DPWIDTH-1:0] imem_addr,
    output logic [DPWIDTH-1:0] imem_datain,
    output logic               imem_ready,
    input  logic               dmem_req,
    input  logic               dmem_we,
    input  logic [DPWIDTH-1:0] dmem_addr,
    input  logic [DPWIDTH-1:0] dmem_dataout,
    output logic [DPWIDTH-1:0] dmem_datain,
    output logic               dmem_ready,
    output logic               mem_err
);

    localparam int AW = $clog2(MEMWORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Misaligned or beyond the array: any set bit above the word index is out of range.
    function automatic logic addr_fault(input logic [DPWIDTH-1:0] a);
        return (a[1:0] != 2'b00) || (a[DPWIDTH-1:AW+2] != '0);
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [3:0]         cnt_r;
    logic               gnt_d_r;
    logic               we_r;
    logic [DPWIDTH-1:0] addr_r;
    logic [DPWIDTH-1:0] wdata_r;
    logic               imem_ready_r;
    logic               dmem_ready_r;
    logic               mem_err_r;
    logic [DPWIDTH-1:0] imem_datain_r;
    logic [DPWIDTH-1:0] dmem_datain_r;
    logic               accept_s;
    logic               access_s;
    logic               fault_s;
    logic [AW-1:0]      idx_s;
    logic [DPWIDTH-1:0] mem_r [MEMWORDS];

    assign fault_s = addr_fault(addr_r);
    assign idx_s   = addr_r[AW+1:2];

    // Next-state decode: accept in IDLE, count down in WAIT, single response cycle.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        access_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (dmem_req || imem_req) begin
                    accept_s = 1'b1;
                    state_s  = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    access_s = 1'b1;
                    state_s  = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, request capture, wait counter and registered responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 4'd0;
            gnt_d_r       <= 1'b0;
            we_r          <= 1'b0;
            addr_r        <= '0;
            wdata_r       <= '0;
            imem_ready_r  <= 1'b0;
            dmem_ready_r  <= 1'b0;
            mem_err_r     <= 1'b0;
            imem_datain_r <= '0;
            dmem_datain_r <= '0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                // Data port has fixed priority; a still-high imem_req is taken next IDLE.
                gnt_d_r <= dmem_req;
                we_r    <= dmem_req & dmem_we;
                addr_r  <= dmem_req ? dmem_addr : imem_addr;
                wdata_r <= dmem_dataout;
                cnt_r   <= dmem_req ? 4'(DWAIT) : 4'(IWAIT);
            end else if (state_r == ST_WAIT && cnt_r != 4'd0) begin
                cnt_r <= cnt_r - 4'd1;
            end
            dmem_ready_r <= access_s & gnt_d_r;
            imem_ready_r <= access_s & ~gnt_d_r;
            mem_err_r    <= access_s & fault_s;
            if (access_s && !fault_s && !we_r) begin
                if (gnt_d_r) begin
                    dmem_datain_r <= mem_r[idx_s];
                end else begin
                    imem_datain_r <= mem_r[idx_s];
                end
            end
        end
    end

    // Array write at the access edge; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (access_s && we_r && !fault_s) begin
            mem_r[idx_s] <= wdata_r;
        end
    end

    assign imem_ready  = imem_ready_r;
    assign dmem_ready  = dmem_ready_r;
    assign mem_err     = mem_err_r;
    assign imem_datain = imem_datain_r;
    assign dmem_datain = dmem_datain_r;

endmodule

// File: tb/tb_rv_mem_resp.sv
// Directed bench for rv_mem_resp (IWAIT=0, DWAIT=2, MEMWORDS=1024); inputs driven and
// outputs sampled on the falling edge.
module tb_rv_mem_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_datain;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_dataout;
    logic [31:0] dmem_datain;
    logic        dmem_ready;
    logic        mem_err;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          dcnt, icnt, dfirst, ifirst;
    logic [31:0] iword;

    always #5 clk = ~clk;

    rv_mem_resp #(.DPWIDTH(32), .MEMWORDS(1024), .IWAIT(0), .DWAIT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_datain(imem_datain),
        .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_dataout(dmem_dataout), .dmem_datain(dmem_datain), .dmem_ready(dmem_ready),
        .mem_err(mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access; gap=1 first waits a falling edge so the FSM is already IDLE.
    task automatic xfer(input logic gap, input logic d, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rdat, output logic e,
                        output int l);
        if (gap) @(negedge clk);
        if (d) begin
            dmem_req = 1'b1; dmem_we = we; dmem_addr = a; dmem_dataout = wd;
        end else begin
            imem_req = 1'b1; imem_addr = a;
        end
        l = 0; rdat = 32'h0; e = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (d ? dmem_ready : imem_ready) begin
                l = i; rdat = d ? dmem_datain : imem_datain; e = mem_err;
                break;
            end else begin
                chk("err_without_ready", {31'd0, mem_err}, 32'd0);
            end
        end
        if (d) dmem_req = 1'b0; else imem_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; imem_req = 1'b0; imem_addr = 32'h0;
        dmem_req = 1'b0; dmem_we = 1'b0; dmem_addr = 32'h0; dmem_dataout = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_imem_ready", {31'd0, imem_ready}, 32'd0);
        chk("rst_dmem_ready", {31'd0, dmem_ready}, 32'd0);
        chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
        chk("rst_imem_datain", imem_datain, 32'h0);
        chk("rst_dmem_datain", dmem_datain, 32'h0);
        rst_n = 1'b1;

        // Known contents at 0x10, then a store aborted by reset mid-WAIT.
        xfer(1'b1, 1'b1, 1'b1, 32'h10, 32'hA5A5A5A5, rd, err, lat);
        chk("t1_pre_store_lat", 32'(lat), 32'd4);
        @(negedge clk);
        dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h10; dmem_dataout = 32'hDEADBEEF;
        @(negedge clk);
        rst_n = 1'b0; dmem_req = 1'b0; dmem_we = 1'b0;
        @(negedge clk);
        chk("t1_in_rst_dmem_ready", {31'd0, dmem_ready}, 32'd0);
        chk("t1_in_rst_err", {31'd0, mem_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_post_rst_dmem_ready", {31'd0, dmem_ready}, 32'd0);
        chk("t1_post_rst_imem_ready", {31'd0, imem_ready}, 32'd0);
        xfer(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, rd, err, lat);
        chk("t1_load_lat", 32'(lat), 32'd4);
        chk("t1_store_dropped", rd, 32'hA5A5A5A5);
        chk("t1_load_err", {31'd0, err}, 32'd0);

        // DWAIT=2 store then load.
        xfer(1'b1, 1'b1, 1'b1, 32'h40, 32'h12345678, rd, err, lat);
        chk("t2_store_lat", 32'(lat), 32'd4);
        chk("t2_store_err", {31'd0, err}, 32'd0);
        chk("t2_store_datain_held", rd, 32'hA5A5A5A5);
        xfer(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, rd, err, lat);
        chk("t2_load_lat", 32'(lat), 32'd4);
        chk("t2_load_data", rd, 32'h12345678);
        chk("t2_load_err", {31'd0, err}, 32'd0);

        // Preload program words, then back-to-back fetches every third cycle.
        xfer(1'b1, 1'b1, 1'b1, 32'h0, 32'h00000013, rd, err, lat);
        xfer(1'b1, 1'b1, 1'b1, 32'h4, 32'h00100093, rd, err, lat);
        xfer(1'b1, 1'b1, 1'b1, 32'h8, 32'h00200113, rd, err, lat);
        xfer(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, rd, err, lat);
        chk("t3_f0_lat", 32'(lat), 32'd2);
        chk("t3_f0_word", rd, 32'h00000013);
        xfer(1'b0, 1'b0, 1'b0, 32'h4, 32'h0, rd, err, lat);
        chk("t3_f1_period", 32'(lat), 32'd3);
        chk("t3_f1_word", rd, 32'h00100093);
        xfer(1'b0, 1'b0, 1'b0, 32'h8, 32'h0, rd, err, lat);
        chk("t3_f2_period", 32'(lat), 32'd3);
        chk("t3_f2_word", rd, 32'h00200113);
        chk("t3_f2_err", {31'd0, err}, 32'd0);

        // Simultaneous requests: data first, fetch right after.
        @(negedge clk);
        dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h80;
        imem_req = 1'b1; imem_addr = 32'h4;
        dcnt = 0; icnt = 0; dfirst = 0; ifirst = 0; iword = 32'h0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (dmem_ready) begin
                dcnt++; if (dfirst == 0) dfirst = i; dmem_req = 1'b0;
            end
            if (imem_ready) begin
                icnt++; if (ifirst == 0) ifirst = i; iword = imem_datain; imem_req = 1'b0;
            end
        end
        chk("t4_dmem_first_at", 32'(dfirst), 32'd4);
        chk("t4_imem_at", 32'(ifirst), 32'd7);
        chk("t4_dmem_count", 32'(dcnt), 32'd1);
        chk("t4_imem_count", 32'(icnt), 32'd1);
        chk("t4_imem_word", iword, 32'h00100093);

        // Faults: misaligned load, out-of-range store.
        xfer(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, rd, err, lat);
        chk("t5_ref_load", rd, 32'h12345678);
        xfer(1'b1, 1'b1, 1'b0, 32'h42, 32'h0, rd, err, lat);
        chk("t5_misal_err", {31'd0, err}, 32'd1);
        chk("t5_misal_lat", 32'(lat), 32'd4);
        chk("t5_misal_datain_held", rd, 32'h12345678);
        xfer(1'b1, 1'b1, 1'b1, 32'h1000, 32'hFFFFFFFF, rd, err, lat);
        chk("t5_oor_err", {31'd0, err}, 32'd1);
        chk("t5_oor_lat", 32'(lat), 32'd4);
        chk("t5_oor_datain_held", rd, 32'h12345678);
        xfer(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, rd, err, lat);
        chk("t5_word0_intact", rd, 32'h00000013);
        chk("t5_word0_err", {31'd0, err}, 32'd0);

        // Request held one cycle past ready: exactly one extra access.
        @(negedge clk);
        dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h40;
        dcnt = 0; dfirst = 0; ifirst = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (dmem_ready) begin
                dcnt++;
                if (dfirst == 0) dfirst = i; else ifirst = i;
            end
            if (dfirst != 0 && i == dfirst + 2) dmem_req = 1'b0;
        end
        chk("t6_held_count", 32'(dcnt), 32'd2);
        chk("t6_extra_ready_gap", 32'(ifirst - dfirst), 32'd5);
        chk("t6_extra_data", dmem_datain, 32'h12345678);

        // Request dropped in the ready cycle: no extra access.
        @(negedge clk);
        dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h40;
        dcnt = 0; dfirst = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (dmem_ready) begin
                dcnt++; if (dfirst == 0) dfirst = i; dmem_req = 1'b0;
            end
        end
        chk("t6_dropped_count", 32'(dcnt), 32'd1);
        chk("t6_dropped_first", 32'(dfirst), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
